// File: rtl/alu_bist_if.sv
// ALU stimulus/response bundle between the BIST engine and the datapath ALU.
//   master (BIST side): drives alu_a, alu_b, alu_cntl, alu_carry_in;
//                       receives alu_out, alu_zero, alu_carry_out, alu_overflow.
//   slave  (ALU side) : the mirror image of master.
// The ALU is purely combinational, so the bundle has no handshake of its own.
interface alu_bist_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_cntl;
  logic             alu_carry_in;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             alu_carry_out;
  logic             alu_overflow;

  modport master (
    output alu_a, alu_b, alu_cntl, alu_carry_in,
    input  alu_out, alu_zero, alu_carry_out, alu_overflow
  );

  modport slave (
    input  alu_a, alu_b, alu_cntl, alu_carry_in,
    output alu_out, alu_zero, alu_carry_out, alu_overflow
  );
endinterface

// File: rtl/alu_bist.sv
// alu_bist: built-in self-test engine for the MIPS datapath ALU.
// Drives pseudo-random operand pairs from two Galois LFSRs, cycles through the
// six ALU operations, and compresses every result plus flags into a 32-bit MISR.
// Ports:
//   clk          - rising-edge clock
//   reset        - synchronous, active-low reset
//   start        - run request (sampled in IDLE or DONE only)
//   expected_sig - golden signature for the pass compare
//   busy         - high while vectors are being applied
//   done         - sticky run-complete flag
//   pass         - done and signature == expected_sig (live compare)
//   signature    - current MISR value
//   dbg_state    - FSM state (0 IDLE, 1 RUN, 2 DONE) for observation
//   alu          - ALU stimulus/response bundle (master side)
//
// Run protocol: start is a request that is accepted on any rising edge where
// the engine is not busy (IDLE or DONE); the accepting edge clears done and the
// first vector appears in the next cycle. While busy is high, start is ignored.
// done rises in the cycle after the last vector and stays high until the next
// accepted start or reset.
module alu_bist #(
  parameter int          WIDTH       = 32,
  parameter int          NUM_VECTORS = 256,
  parameter logic [31:0] SEED_A      = 32'h0000_0001,
  parameter logic [31:0] SEED_B      = 32'h0000_ACE1,
  parameter logic [31:0] SIG_INIT    = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] expected_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [1:0]       dbg_state,
  alu_bist_if.master       alu
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] LFSR_POLY  = 32'h8020_0003;
  localparam logic [WIDTH-1:0] MISR_POLY  = 32'h04C1_1DB7;
  // A zero seed would lock the LFSR at zero forever.
  localparam logic [WIDTH-1:0] SEED_A_EFF = (SEED_A == '0) ? 32'h1 : SEED_A;
  localparam logic [WIDTH-1:0] SEED_B_EFF = (SEED_B == '0) ? 32'h1 : SEED_B;
  localparam logic [15:0]      LAST_VEC   = 16'(NUM_VECTORS - 1);

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_POLY : '0);
  endfunction

  function automatic logic [3:0] op_code(input logic [2:0] idx);
    case (idx)
      3'd0:    return 4'b0000; // AND
      3'd1:    return 4'b0001; // OR
      3'd2:    return 4'b0010; // ADD
      3'd3:    return 4'b0110; // SUB
      3'd4:    return 4'b0111; // SLT
      3'd5:    return 4'b1100; // NOR
      default: return 4'b0000;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_a_q, lfsr_a_d;
  logic [WIDTH-1:0] lfsr_b_q, lfsr_b_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [15:0]      vcnt_q, vcnt_d;
  logic [2:0]       op_idx_q, op_idx_d;

  logic [WIDTH-1:0] a_o, b_o;
  logic [3:0]       cntl_o;
  logic             cin_o;
  logic [WIDTH-1:0] misr_in;
  logic [WIDTH-1:0] sig_shift;

  always_comb begin
    state_d  = state_q;
    lfsr_a_d = lfsr_a_q;
    lfsr_b_d = lfsr_b_q;
    sig_d    = sig_q;
    vcnt_d   = vcnt_q;
    op_idx_d = op_idx_q;
    a_o      = '0;
    b_o      = '0;
    cntl_o   = '0;
    cin_o    = 1'b0;

    misr_in   = alu.alu_out ^ {{(WIDTH-3){1'b0}}, alu.alu_zero,
                               alu.alu_carry_out, alu.alu_overflow};
    sig_shift = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? MISR_POLY : '0);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_RUN;
          lfsr_a_d = SEED_A_EFF;
          lfsr_b_d = SEED_B_EFF;
          sig_d    = SIG_INIT;
          vcnt_d   = '0;
          op_idx_d = '0;
        end
      end
      ST_RUN: begin
        a_o    = lfsr_a_q;
        b_o    = lfsr_b_q;
        cntl_o = op_code(op_idx_q);
        cin_o  = lfsr_b_q[WIDTH-1];
        // The combinational ALU result for this vector is folded in at the
        // same edge that advances to the next vector.
        sig_d    = sig_shift ^ misr_in;
        lfsr_a_d = lfsr_step(lfsr_a_q);
        lfsr_b_d = lfsr_step(lfsr_b_q);
        vcnt_d   = vcnt_q + 16'd1;
        op_idx_d = (op_idx_q == 3'd5) ? 3'd0 : op_idx_q + 3'd1;
        if (vcnt_q == LAST_VEC) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      lfsr_a_q <= SEED_A_EFF;
      lfsr_b_q <= SEED_B_EFF;
      sig_q    <= SIG_INIT;
      vcnt_q   <= '0;
      op_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_a_q <= lfsr_a_d;
      lfsr_b_q <= lfsr_b_d;
      sig_q    <= sig_d;
      vcnt_q   <= vcnt_d;
      op_idx_q <= op_idx_d;
    end
  end

  assign alu.alu_a        = a_o;
  assign alu.alu_b        = b_o;
  assign alu.alu_cntl     = cntl_o;
  assign alu.alu_carry_in = cin_o;

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign pass      = (state_q == ST_DONE) && (sig_q == expected_sig);
  assign signature = sig_q;
  assign dbg_state = state_q;

endmodule
